wbb2wb: RTL and testbench



---
 rtl/wbb_pkg.sv | 12 +
 rtl/wbb2wb.sv | 125 ++++++++++++
 tb/tb_wbb2wb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wbb_pkg.sv
// Shared types for the burst-to-single Wishbone splitter.
package wbb_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      RESP = 3'd2,
      GAP  = 3'd3,
      NEXT = 3'd4
   } state_t;

endpackage

// File: rtl/wbb2wb.sv
// Replays one upstream Wishbone burst as bl classic single accesses at ascending addresses.
// Each beat takes >=4 cycles (REQ, RESP, GAP, NEXT); slave wait states stretch REQ, bry low stalls RESP/NEXT.
module wbb2wb
   import wbb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int BW = 4,
   parameter int BL = 10
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          wbm_cyc_i,
   input  logic          wbm_stb_i,
   input  logic [AW-1:0] wbm_adr_i,
   input  logic          wbm_we_i,
   input  logic [DW-1:0] wbm_dat_i,
   input  logic [BW-1:0] wbm_sel_i,
   input  logic [BL-1:0] wbm_bl_i,
   input  logic          wbm_bry_i,
   output logic [DW-1:0] wbm_dat_o,
   output logic          wbm_ack_o,
   output logic          wbm_lack_o,
   output logic          wbm_err_o,
   output logic          wbs_cyc_o,
   output logic          wbs_stb_o,
   output logic [AW-1:0] wbs_adr_o,
   output logic          wbs_we_o,
   output logic [DW-1:0] wbs_dat_o,
   output logic [BW-1:0] wbs_sel_o,
   input  logic [DW-1:0] wbs_dat_i,
   input  logic          wbs_ack_i,
   input  logic          wbs_err_i
);

   state_t        state;
   logic [BL-1:0] cnt;
   logic          err_beat;
   logic          accept;
   logic          last_beat;

   // Gating on lack keeps the still-asserted strobe of a finished burst from restarting it.
   assign accept    = wbm_stb_i & wbm_cyc_i & wbm_bry_i & ~wbm_lack_o;
   assign last_beat = (cnt == BL'(1));

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         err_beat   <= 1'b0;
         wbm_dat_o  <= '0;
         wbm_ack_o  <= 1'b0;
         wbm_lack_o <= 1'b0;
         wbm_err_o  <= 1'b0;
         wbs_cyc_o  <= 1'b0;
         wbs_stb_o  <= 1'b0;
         wbs_adr_o  <= '0;
         wbs_we_o   <= 1'b0;
         wbs_dat_o  <= '0;
         wbs_sel_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               wbm_ack_o  <= 1'b0;
               wbm_lack_o <= 1'b0;
               wbm_err_o  <= 1'b0;
               if (accept) begin
                  wbs_adr_o <= wbm_adr_i;
                  wbs_we_o  <= wbm_we_i;
                  wbs_sel_o <= wbm_sel_i;
                  wbs_dat_o <= wbm_dat_i;
                  cnt       <= (wbm_bl_i == '0) ? BL'(1) : wbm_bl_i;
                  wbs_cyc_o <= 1'b1;
                  wbs_stb_o <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               // The downstream access runs to completion regardless of upstream cyc.
               if (wbs_ack_i | wbs_err_i) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  if (!wbs_we_o) wbm_dat_o <= wbs_dat_i;
                  err_beat  <= wbs_err_i;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (!wbm_cyc_i) begin
                  state <= IDLE;
               end else if (wbm_bry_i) begin
                  wbm_ack_o  <= 1'b1;
                  wbm_err_o  <= err_beat;
                  wbm_lack_o <= last_beat;
                  if (last_beat) begin
                     state <= IDLE;
                  end else begin
                     cnt       <= cnt - BL'(1);
                     wbs_adr_o <= wbs_adr_o + AW'(BW);
                     state     <= GAP;
                  end
               end
            end
            GAP: begin
               wbm_ack_o  <= 1'b0;
               wbm_lack_o <= 1'b0;
               wbm_err_o  <= 1'b0;
               state      <= NEXT;
            end
            NEXT: begin
               if (!wbm_cyc_i) begin
                  state <= IDLE;
               end else if (wbm_bry_i) begin
                  if (wbs_we_o) wbs_dat_o <= wbm_dat_i;
                  wbs_cyc_o <= 1'b1;
                  wbs_stb_o <= 1'b1;
                  state     <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wbb2wb.sv
module tb_wbb2wb;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
   } ds_t;

   typedef struct {
      logic [31:0] dat;
      logic        we;
      logic        err;
      logic        lack;
   } up_t;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        wbm_cyc_i = 1'b0, wbm_stb_i = 1'b0, wbm_we_i = 1'b0, wbm_bry_i = 1'b0;
   logic [31:0] wbm_adr_i = '0, wbm_dat_i = '0;
   logic [3:0]  wbm_sel_i = '0;
   logic [9:0]  wbm_bl_i = '0;
   logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_dat_i;
   logic        wbm_ack_o, wbm_lack_o, wbm_err_o;
   logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i, wbs_err_i;
   logic [3:0]  wbs_sel_o;

   // slave model controls
   int          max_wait = 0;
   int          wait_left = 0;
   logic        slv_hold = 1'b0;
   logic [31:0] err_adr = 32'h1;
   logic        slv_hit;

   ds_t exp_ds[$];
   up_t exp_up[$];
   int  n_pass = 0, n_total = 0;
   logic prev_ack = 1'b0;
   int   low_cnt = 99;

   always #5 clk_i = ~clk_i;

   wbb2wb #(.AW(32), .DW(32), .BW(4), .BL(10)) dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_adr_i(wbm_adr_i),
      .wbm_we_i(wbm_we_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
      .wbm_bl_i(wbm_bl_i), .wbm_bry_i(wbm_bry_i),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_lack_o(wbm_lack_o),
      .wbm_err_o(wbm_err_o),
      .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_adr_o(wbs_adr_o),
      .wbs_we_o(wbs_we_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
   );

   // Peripheral slave: random wait states, combinational response, error at one chosen address.
   assign slv_hit   = wbs_cyc_o & wbs_stb_o & (wait_left == 0) & ~slv_hold;
   assign wbs_ack_i = slv_hit & (wbs_adr_o != err_adr);
   assign wbs_err_i = slv_hit & (wbs_adr_o == err_adr);
   assign wbs_dat_i = wbs_adr_o ^ 32'hA5A5A5A5;

   always @(posedge clk_i) begin
      if (wbs_cyc_o && wbs_stb_o && !slv_hold) begin
         if (wait_left > 0) wait_left <= wait_left - 1;
         else               wait_left <= $urandom_range(0, max_wait);
      end
   end

   task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // downstream monitor
   always @(negedge clk_i) begin
      ds_t e;
      low_cnt <= (!rst_n) ? 99 : (wbs_stb_o ? 0 : low_cnt + 1);
      if (rst_n && wbs_stb_o && low_cnt != 0)
         chk("stb_gap", low_cnt >= 2, 64'(low_cnt), 64'd2);
      if (slv_hit) begin
         chk("ds_expected", exp_ds.size() != 0, 64'(exp_ds.size()), 64'd1);
         if (exp_ds.size() != 0) begin
            e = exp_ds.pop_front();
            chk("ds_adr", wbs_adr_o == e.adr, 64'(wbs_adr_o), 64'(e.adr));
            chk("ds_we", wbs_we_o == e.we, 64'(wbs_we_o), 64'(e.we));
            chk("ds_sel", wbs_sel_o == e.sel, 64'(wbs_sel_o), 64'(e.sel));
            if (e.we) chk("ds_wdat", wbs_dat_o == e.dat, 64'(wbs_dat_o), 64'(e.dat));
         end
      end
   end

   // upstream monitor
   always @(negedge clk_i) begin
      up_t e;
      prev_ack <= wbm_ack_o;
      if (wbm_ack_o) begin
         chk("ack_spacing", !prev_ack, 64'(prev_ack), 64'd0);
         chk("up_expected", exp_up.size() != 0, 64'(exp_up.size()), 64'd1);
         if (exp_up.size() != 0) begin
            e = exp_up.pop_front();
            if (!e.we) chk("rd_data", wbm_dat_o == e.dat, 64'(wbm_dat_o), 64'(e.dat));
            chk("err", wbm_err_o == e.err, 64'(wbm_err_o), 64'(e.err));
            chk("lack", wbm_lack_o == e.lack, 64'(wbm_lack_o), 64'(e.lack));
         end
      end
   end

   // One upstream burst. abort_at>0 drops cyc after that many acks; hold2 forces bry low before beat 2.
   task automatic burst(input logic [31:0] adr, input logic we, input logic [9:0] bl,
                        input int abort_at, input int stall, input int hold2);
      int          beats, acks, cyc_n, held;
      logic [31:0] wd[$];
      logic [31:0] ba;
      logic [3:0]  sel;
      logic        timed_out;
      beats = (bl == 0) ? 1 : int'(bl);
      sel   = 4'($urandom_range(1, 15));
      for (int i = 0; i < beats; i++) begin
         wd.push_back($urandom);
         if (abort_at <= 0 || i < abort_at) begin
            ba = adr + 32'(4 * i);
            exp_ds.push_back('{adr: ba, we: we, dat: wd[i], sel: sel});
            exp_up.push_back('{dat: ba ^ 32'hA5A5A5A5, we: we, err: (ba == err_adr),
                               lack: (i == beats - 1)});
         end
      end
      @(negedge clk_i);
      wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_adr_i = adr; wbm_we_i = we;
      wbm_sel_i = sel;  wbm_bl_i = bl;
      acks = 0; cyc_n = 0; held = 0; timed_out = 1'b0;
      while (1) begin
         if (acks == 1 && held < hold2) begin
            wbm_bry_i = 1'b0;
            held++;
         end else begin
            wbm_bry_i = ($urandom_range(0, 99) >= stall);
         end
         wbm_dat_i = wbm_bry_i ? wd[acks] : $urandom;
         @(negedge clk_i);
         cyc_n++;
         if (wbm_ack_o) begin
            acks++;
            if (wbm_lack_o || acks >= beats || acks == abort_at) break;
         end
         if (cyc_n > 400) begin
            timed_out = 1'b1;
            break;
         end
      end
      chk("burst_done", !timed_out, 64'(acks), 64'(beats));
      wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_bry_i = 1'b0; wbm_dat_i = '0;
      repeat (4) @(negedge clk_i);
      chk("ds_drain", exp_ds.size() == 0, 64'(exp_ds.size()), 64'd0);
      chk("up_drain", exp_up.size() == 0, 64'(exp_up.size()), 64'd0);
      exp_ds.delete();
      exp_up.delete();
   endtask

   function automatic logic [123:0] all_outs();
      return {wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o,
              wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o};
   endfunction

   initial begin
      logic [31:0] a;
      int          n;
      repeat (3) @(negedge clk_i);
      chk("reset_outputs", all_outs() == '0, 64'(all_outs()), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_i);

      // read burst, zero-wait slave
      burst(32'h100, 1'b0, 10'd4, -1, 0, 0);
      // write burst with bry held low before beat 2
      max_wait = 1;
      burst(32'h2000, 1'b1, 10'd3, -1, 0, 5);
      // bl=0 and bl=1
      max_wait = 0;
      burst(32'h40, 1'b0, 10'd0, -1, 0, 0);
      burst(32'h44, 1'b0, 10'd1, -1, 20, 0);
      // error on beat 2 of 3
      err_adr = 32'h204;
      burst(32'h200, 1'b0, 10'd3, -1, 0, 0);
      err_adr = 32'h1;
      // abort in NEXT after beat 1, then a normal burst
      burst(32'h300, 1'b0, 10'd4, 1, 0, 0);
      burst(32'h400, 1'b1, 10'd2, -1, 0, 0);

      // async reset while the slave stalls in REQ
      slv_hold = 1'b1;
      @(negedge clk_i);
      wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_bry_i = 1'b1; wbm_adr_i = 32'h500;
      wbm_we_i = 1'b0; wbm_bl_i = 10'd4; wbm_sel_i = 4'hF;
      n = 0;
      while (!wbs_stb_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      chk("req_reached", wbs_stb_o, 64'(wbs_stb_o), 64'd1);
      repeat (2) @(negedge clk_i);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", all_outs() == '0, 64'(all_outs()), 64'd0);
      wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_bry_i = 1'b0;
      slv_hold = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("post_reset_idle", all_outs() == '0, 64'(all_outs()), 64'd0);
      // address wrap at top of space
      burst(32'hFFFF_FFFC, 1'b0, 10'd2, -1, 0, 0);

      // randomized bursts
      for (int k = 0; k < 30; k++) begin
         max_wait = $urandom_range(0, 3);
         a = $urandom;
         a[1:0] = 2'b00;
         if (k % 7 == 3) a = 32'hFFFF_FFF0;
         n = $urandom_range(0, 6);
         err_adr = ($urandom_range(0, 2) == 0) ? a + 32'(4 * $urandom_range(0, 5)) : 32'h1;
         burst(a, 1'($urandom_range(0, 1)), 10'(n),
               ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : -1,
               $urandom_range(0, 50), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
